// File: rtl/sc_istream_aligner.sv
// Instruction-stream aligner: splits raw byte chunks into 2/4/6/8-byte RISC-V
// instructions and queues one length/encoding record per instruction.
module sc_istream_aligner #(
  parameter int  STREAM_BYTES    = 34,
  parameter int  INSN_MAX_BYTES  = 8,
  parameter int  LIST_CAP        = 16,
  parameter bit  DISCARD_REMNANT = 1'b1,
  localparam int NB_W            = $clog2(STREAM_BYTES + 1),
  localparam int LC_W            = $clog2(LIST_CAP + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [STREAM_BYTES*8-1:0] in_data,
  input  logic [NB_W-1:0]           in_nbytes,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_len,
  output logic [63:0]               out_ins,
  output logic                      out_ill,
  output logic [LC_W-1:0]           list_cnt,
  output logic                      remnant_drop,
  output logic [7:0]                remnant_bytes
);

  localparam int BUF_BYTES = STREAM_BYTES + INSN_MAX_BYTES;
  localparam int BUF_W     = BUF_BYTES * 8;
  localparam int CNT_W     = $clog2(BUF_BYTES + 1);
  localparam int PTR_W     = (LIST_CAP > 1) ? $clog2(LIST_CAP) : 1;
  localparam int REC_W     = 1 + 4 + 64;

  localparam logic [3:0]       MAX_LEN   = 4'(INSN_MAX_BYTES);
  localparam logic [CNT_W-1:0] READY_LIM = CNT_W'(INSN_MAX_BYTES);
  localparam logic [NB_W-1:0]  NB_MAX    = NB_W'(STREAM_BYTES);
  localparam logic [LC_W-1:0]  LIST_FULL = LC_W'(LIST_CAP);

  // Encoded length of the instruction whose first byte is b; 0 means illegal.
  function automatic logic [3:0] decode_len(input logic [7:0] b);
    logic [3:0] len;
    if (b[1:0] != 2'b11) begin
      len = 4'd2;
    end else if (b[4:2] != 3'b111) begin
      len = 4'd4;
    end else if (!b[5]) begin
      len = 4'd6;
    end else if (!b[6]) begin
      len = 4'd8;
    end else begin
      len = 4'd0;
    end
    return len;
  endfunction

  logic [BUF_W-1:0] byte_buf_r;
  logic [CNT_W-1:0] cnt_r;
  logic             eos_pend_r;
  logic [REC_W-1:0] mem [LIST_CAP];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LC_W-1:0]  list_cnt_r;
  logic             remnant_drop_r;
  logic [7:0]       remnant_bytes_r;

  logic [3:0]       dec_len_s;
  logic [3:0]       len_eff_s;
  logic             ill_s;
  logic             buf_ok_s;
  logic             full_s;
  logic             accept_s;
  logic             extract_s;
  logic             drop_s;
  logic             pop_s;
  logic [NB_W-1:0]  nb_s;
  logic [CNT_W-1:0] len_x_s;
  logic [CNT_W-1:0] keep_cnt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [BUF_W-1:0] in_masked_s;
  logic [BUF_W-1:0] shifted_s;
  logic [BUF_W-1:0] buf_nxt_s;
  logic [63:0]      rec_ins_s;
  logic             eos_nxt_s;
  logic [REC_W-1:0] head_s;

  assign in_ready = (cnt_r <= READY_LIM) && !flush;

  // Decode, extraction/discard decisions and next buffer contents.
  always_comb begin
    dec_len_s = decode_len(byte_buf_r[7:0]);
    ill_s     = (dec_len_s == 4'd0) || (dec_len_s > MAX_LEN);
    len_eff_s = ill_s ? 4'd2 : dec_len_s;
    buf_ok_s  = (cnt_r >= CNT_W'(2)) && (cnt_r >= CNT_W'(len_eff_s));
    full_s    = (list_cnt_r == LIST_FULL);
    accept_s  = in_valid && in_ready;
    extract_s = buf_ok_s && !full_s && !flush;
    drop_s    = eos_pend_r && !buf_ok_s && !full_s && !flush;
    pop_s     = out_valid && out_ready && !flush;
    nb_s      = (in_nbytes > NB_MAX) ? NB_MAX : in_nbytes;

    // Bytes past in_nbytes are zeroed so the buffer stays clean above cnt.
    in_masked_s = '0;
    for (int k = 0; k < STREAM_BYTES; k++) begin
      if (NB_W'(k) < nb_s) begin
        in_masked_s[8*k +: 8] = in_data[8*k +: 8];
      end else begin
        in_masked_s[8*k +: 8] = 8'h00;
      end
    end

    rec_ins_s = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < len_eff_s) begin
        rec_ins_s[8*k +: 8] = byte_buf_r[8*k +: 8];
      end else begin
        rec_ins_s[8*k +: 8] = 8'h00;
      end
    end

    len_x_s = extract_s ? CNT_W'(len_eff_s) : '0;
    if (drop_s && DISCARD_REMNANT) begin
      shifted_s  = '0;
      keep_cnt_s = '0;
    end else begin
      shifted_s  = byte_buf_r >> {len_x_s, 3'b000};
      keep_cnt_s = cnt_r - len_x_s;
    end

    // New bytes land directly after whatever survives the shift.
    if (accept_s) begin
      buf_nxt_s = shifted_s | (in_masked_s << {keep_cnt_s, 3'b000});
      cnt_nxt_s = keep_cnt_s + CNT_W'(nb_s);
    end else begin
      buf_nxt_s = shifted_s;
      cnt_nxt_s = keep_cnt_s;
    end

    if (accept_s && in_last) begin
      eos_nxt_s = 1'b1;
    end else if (drop_s) begin
      eos_nxt_s = 1'b0;
    end else begin
      eos_nxt_s = eos_pend_r;
    end
  end

  // Buffer, stream state, list pointers and remnant reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_buf_r      <= '0;
      cnt_r           <= '0;
      eos_pend_r      <= 1'b0;
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      list_cnt_r      <= '0;
      remnant_drop_r  <= 1'b0;
      remnant_bytes_r <= 8'h00;
    end else if (flush) begin
      byte_buf_r      <= '0;
      cnt_r           <= '0;
      eos_pend_r      <= 1'b0;
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      list_cnt_r      <= '0;
      remnant_drop_r  <= 1'b0;
    end else begin
      byte_buf_r     <= buf_nxt_s;
      cnt_r          <= cnt_nxt_s;
      eos_pend_r     <= eos_nxt_s;
      remnant_drop_r <= drop_s && DISCARD_REMNANT;
      if (drop_s && DISCARD_REMNANT) begin
        remnant_bytes_r <= 8'(cnt_r);
      end
      if (extract_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (extract_s && !pop_s) begin
        list_cnt_r <= list_cnt_r + LC_W'(1);
      end else if (pop_s && !extract_s) begin
        list_cnt_r <= list_cnt_r - LC_W'(1);
      end
    end
  end

  // Record storage; entries are qualified by list_cnt so they carry no reset.
  always_ff @(posedge clk) begin
    if (extract_s) begin
      mem[wr_ptr_r] <= {ill_s, len_eff_s, rec_ins_s};
    end
  end

  assign head_s        = mem[rd_ptr_r];
  assign out_valid     = (list_cnt_r != '0);
  assign out_len       = out_valid ? {4'h0, head_s[67:64]} : 8'h00;
  assign out_ins       = out_valid ? head_s[63:0] : 64'h0;
  assign out_ill       = out_valid ? head_s[68] : 1'b0;
  assign list_cnt      = list_cnt_r;
  assign remnant_drop  = remnant_drop_r;
  assign remnant_bytes = remnant_bytes_r;

endmodule

// File: tb/tb_sc_istream_aligner.sv
// Directed bench for sc_istream_aligner: a default instance (8-byte max,
// discard remnant) and a 4-byte-max instance that carries remnants.
module tb_sc_istream_aligner;
  localparam int SB = 34;
  localparam int DW = SB * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m_flush = 1'b0, m_in_valid = 1'b0, m_in_last = 1'b0, m_out_ready = 1'b0;
  logic [DW-1:0] m_in_data = '0;
  logic [5:0]    m_in_nbytes = '0;
  logic          m_in_ready, m_out_valid, m_out_ill, m_remnant_drop;
  logic [7:0]    m_out_len, m_remnant_bytes;
  logic [63:0]   m_out_ins;
  logic [4:0]    m_list_cnt;

  logic          a_flush = 1'b0, a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b0;
  logic [DW-1:0] a_in_data = '0;
  logic [5:0]    a_in_nbytes = '0;
  logic          a_in_ready, a_out_valid, a_out_ill, a_remnant_drop;
  logic [7:0]    a_out_len, a_remnant_bytes;
  logic [63:0]   a_out_ins;
  logic [4:0]    a_list_cnt;

  sc_istream_aligner u_main (
    .clk(clk), .rst_n(rst_n), .flush(m_flush),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .in_nbytes(m_in_nbytes), .in_last(m_in_last),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_len(m_out_len),
    .out_ins(m_out_ins), .out_ill(m_out_ill), .list_cnt(m_list_cnt),
    .remnant_drop(m_remnant_drop), .remnant_bytes(m_remnant_bytes)
  );

  sc_istream_aligner #(.INSN_MAX_BYTES(4), .DISCARD_REMNANT(1'b0)) u_alt (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_nbytes(a_in_nbytes), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_len(a_out_len),
    .out_ins(a_out_ins), .out_ill(a_out_ill), .list_cnt(a_list_cnt),
    .remnant_drop(a_remnant_drop), .remnant_bytes(a_remnant_bytes)
  );

  int checks = 0;
  int passes = 0;
  int m_drop_count = 0;
  int a_drop_count = 0;

  always @(negedge clk) begin
    if (m_remnant_drop) m_drop_count++;
    if (a_remnant_drop) a_drop_count++;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_m(input logic [DW-1:0] data, input logic [5:0] nb, input logic last);
    int w = 0;
    while (!m_in_ready && w < 40) begin step(1); w++; end
    checks++;
    if (!m_in_ready) $display("FAIL send_m_timeout: in_ready=%0b want 1", m_in_ready);
    else passes++;
    m_in_data = data; m_in_nbytes = nb; m_in_last = last; m_in_valid = 1'b1;
    step(1);
    m_in_valid = 1'b0; m_in_last = 1'b0;
  endtask

  task automatic send_a(input logic [DW-1:0] data, input logic [5:0] nb, input logic last);
    int w = 0;
    while (!a_in_ready && w < 40) begin step(1); w++; end
    checks++;
    if (!a_in_ready) $display("FAIL send_a_timeout: in_ready=%0b want 1", a_in_ready);
    else passes++;
    a_in_data = data; a_in_nbytes = nb; a_in_last = last; a_in_valid = 1'b1;
    step(1);
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic pop_m(output logic v, output logic [72:0] rec);
    int w = 0;
    while (!m_out_valid && w < 40) begin step(1); w++; end
    v = m_out_valid;
    rec = {m_out_len, m_out_ins, m_out_ill};
    if (v) begin
      m_out_ready = 1'b1; step(1); m_out_ready = 1'b0;
    end
  endtask

  task automatic pop_a(output logic v, output logic [72:0] rec);
    int w = 0;
    while (!a_out_valid && w < 40) begin step(1); w++; end
    v = a_out_valid;
    rec = {a_out_len, a_out_ins, a_out_ill};
    if (v) begin
      a_out_ready = 1'b1; step(1); a_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    step(1);
    checks++;
    if ({m_in_ready, m_out_valid, m_out_len, m_out_ins, m_out_ill, m_list_cnt, m_remnant_drop, m_remnant_bytes}
        !== {1'b1, 1'b0, 8'd0, 64'd0, 1'b0, 5'd0, 1'b0, 8'd0})
      $display("FAIL reset_values: rdy=%0b vld=%0b len=%0d ins=%h ill=%0b cnt=%0d drop=%0b rb=%0d want 1/0/0/0/0/0/0/0",
               m_in_ready, m_out_valid, m_out_len, m_out_ins, m_out_ill, m_list_cnt, m_remnant_drop, m_remnant_bytes);
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (m_in_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", m_in_ready);
    else passes++;
    step(1);
    send_m(DW'(32'h0001_0001), 6'd4, 1'b0);
    step(1);
    checks++;
    if ({m_out_valid, m_list_cnt} !== {1'b1, 5'd1}) $display("FAIL reset_pre_fill: vld=%0b cnt=%0d want 1/1", m_out_valid, m_list_cnt);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_out_valid, m_list_cnt, m_in_ready, m_out_len} !== {1'b0, 5'd0, 1'b1, 8'd0})
      $display("FAIL reset_async: vld=%0b cnt=%0d rdy=%0b len=%0d want 0/0/1/0", m_out_valid, m_list_cnt, m_in_ready, m_out_len);
    else passes++;
    step(1);
    rst_n = 1'b1;
    step(2);
    checks++;
    if ({m_out_valid, m_list_cnt} !== {1'b0, 5'd0}) $display("FAIL reset_no_stale: vld=%0b cnt=%0d want 0/0", m_out_valid, m_list_cnt);
    else passes++;
  endtask

  task automatic test_mixed();
    logic v;
    logic [72:0] rec;
    logic [72:0] exp_rec [3] = '{{8'd2, 64'h1141, 1'b0}, {8'd4, 64'h0010_0093, 1'b0}, {8'd2, 64'h4505, 1'b0}};
    m_in_data = DW'(80'h003F_4505_0010_0093_1141); m_in_nbytes = 6'd10; m_in_valid = 1'b1;
    step(1);
    m_in_valid = 1'b0;
    checks++;
    if ({m_out_valid, m_in_ready} !== 2'b00) $display("FAIL mixed_after_accept: vld=%0b rdy=%0b want 0/0", m_out_valid, m_in_ready);
    else passes++;
    step(1);
    checks++;
    if ({m_out_valid, m_out_len, m_out_ins} !== {1'b1, 8'd2, 64'h1141})
      $display("FAIL mixed_latency: vld=%0b len=%0d ins=%h want 1/2/1141", m_out_valid, m_out_len, m_out_ins);
    else passes++;
    for (int r = 0; r < 3; r++) begin
      pop_m(v, rec);
      checks++;
      if (!v || rec !== exp_rec[r]) $display("FAIL mixed_rec%0d: valid=%0b got %h want %h", r, v, rec, exp_rec[r]);
      else passes++;
    end
    step(3);
    checks++;
    if ({m_list_cnt, m_in_ready} !== {5'd0, 1'b1}) $display("FAIL mixed_wait8: cnt=%0d rdy=%0b want 0/1", m_list_cnt, m_in_ready);
    else passes++;
    send_m(DW'(48'h6655_4433_2211), 6'd6, 1'b0);
    pop_m(v, rec);
    checks++;
    if (!v || rec !== {8'd8, 64'h6655_4433_2211_003F, 1'b0}) $display("FAIL mixed_len8: valid=%0b got %h", v, rec);
    else passes++;
  endtask

  task automatic test_illegal();
    logic v;
    logic [72:0] rec;
    send_m(DW'(32'h0001_007F), 6'd4, 1'b0);
    pop_m(v, rec);
    checks++;
    if (!v || rec !== {8'd2, 64'h007F, 1'b1}) $display("FAIL illegal_rec: valid=%0b got %h want 2/007f/1", v, rec);
    else passes++;
    pop_m(v, rec);
    checks++;
    if (!v || rec !== {8'd2, 64'h0001, 1'b0}) $display("FAIL illegal_resume: valid=%0b got %h want 2/0001/0", v, rec);
    else passes++;
  endtask

  task automatic test_discard();
    logic v;
    logic [72:0] rec;
    m_in_data = DW'(40'h10_0093_0001); m_in_nbytes = 6'd5; m_in_last = 1'b1; m_in_valid = 1'b1;
    step(1);
    m_in_valid = 1'b0; m_in_last = 1'b0;
    checks++;
    if ({m_out_valid, m_remnant_drop} !== 2'b00) $display("FAIL discard_n: vld=%0b drop=%0b want 0/0", m_out_valid, m_remnant_drop);
    else passes++;
    step(1);
    checks++;
    if ({m_out_valid, m_remnant_drop, m_list_cnt} !== {1'b1, 1'b0, 5'd1})
      $display("FAIL discard_push: vld=%0b drop=%0b cnt=%0d want 1/0/1", m_out_valid, m_remnant_drop, m_list_cnt);
    else passes++;
    step(1);
    checks++;
    if ({m_remnant_drop, m_remnant_bytes, m_in_ready} !== {1'b1, 8'd3, 1'b1})
      $display("FAIL discard_pulse: drop=%0b bytes=%0d rdy=%0b want 1/3/1", m_remnant_drop, m_remnant_bytes, m_in_ready);
    else passes++;
    step(1);
    checks++;
    if ({m_remnant_drop, m_remnant_bytes} !== {1'b0, 8'd3}) $display("FAIL discard_hold: drop=%0b bytes=%0d want 0/3", m_remnant_drop, m_remnant_bytes);
    else passes++;
    pop_m(v, rec);
    checks++;
    if (!v || rec !== {8'd2, 64'h0001, 1'b0}) $display("FAIL discard_rec: valid=%0b got %h", v, rec);
    else passes++;
    // Empty remnant still pulses, and leftover-free buffer proves cnt was cleared.
    m_in_data = DW'(16'h0001); m_in_nbytes = 6'd2; m_in_last = 1'b1; m_in_valid = 1'b1;
    step(1);
    m_in_valid = 1'b0; m_in_last = 1'b0;
    step(1);
    checks++;
    if ({m_remnant_drop, m_list_cnt} !== {1'b0, 5'd1}) $display("FAIL discard_zero_pre: drop=%0b cnt=%0d want 0/1", m_remnant_drop, m_list_cnt);
    else passes++;
    step(1);
    checks++;
    if ({m_remnant_drop, m_remnant_bytes} !== {1'b1, 8'd0}) $display("FAIL discard_zero: drop=%0b bytes=%0d want 1/0", m_remnant_drop, m_remnant_bytes);
    else passes++;
    pop_m(v, rec);
    checks++;
    if (!v || rec !== {8'd2, 64'h0001, 1'b0}) $display("FAIL discard_cnt0: valid=%0b got %h", v, rec);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    int k;
    d = '0;
    for (int i = 0; i < 17; i++) begin
      d[16*i +: 8] = 8'h01;
      d[16*i+8 +: 8] = 8'(i);
    end
    m_out_ready = 1'b0;
    m_in_data = d; m_in_nbytes = 6'd63; m_in_valid = 1'b1;
    step(1);
    m_in_valid = 1'b0;
    checks++;
    if (m_in_ready !== 1'b0) $display("FAIL bp_ready_low: got %0b want 0", m_in_ready);
    else passes++;
    step(20);
    checks++;
    if (m_list_cnt !== 5'd16) $display("FAIL bp_saturate: cnt=%0d want 16", m_list_cnt);
    else passes++;
    d = '0;
    for (int i = 0; i < 3; i++) begin
      d[16*i +: 8] = 8'h01;
      d[16*i+8 +: 8] = 8'(i + 17);
    end
    send_m(d, 6'd6, 1'b0);
    step(4);
    checks++;
    if ({m_list_cnt, m_in_ready} !== {5'd16, 1'b1}) $display("FAIL bp_full_hold: cnt=%0d rdy=%0b want 16/1", m_list_cnt, m_in_ready);
    else passes++;
    m_out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 80 && k < 20; c++) begin
      if (m_out_valid) begin
        checks++;
        if ({m_out_len, m_out_ins, m_out_ill} !== {8'd2, 48'd0, 8'(k), 8'h01, 1'b0})
          $display("FAIL bp_rec%0d: len=%0d ins=%h ill=%0b want 2/%02x01/0", k, m_out_len, m_out_ins, m_out_ill, k);
        else passes++;
        k++;
      end
      step(1);
    end
    m_out_ready = 1'b0;
    step(2);
    checks++;
    if (k !== 20 || m_list_cnt !== 5'd0) $display("FAIL bp_total: records=%0d cnt=%0d want 20/0", k, m_list_cnt);
    else passes++;
  endtask

  task automatic test_flush();
    logic [DW-1:0] d;
    int drops0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[16*i +: 8] = 8'h01;
      d[16*i+8 +: 8] = 8'(i);
    end
    d[64 +: 8] = 8'h93;
    m_in_data = d; m_in_nbytes = 6'd9; m_in_last = 1'b1; m_in_valid = 1'b1;
    step(1);
    m_in_valid = 1'b0; m_in_last = 1'b0;
    step(2);
    checks++;
    if (m_list_cnt !== 5'd2) $display("FAIL flush_pre: cnt=%0d want 2", m_list_cnt);
    else passes++;
    drops0 = m_drop_count;
    m_flush = 1'b1; m_in_valid = 1'b1; m_in_nbytes = 6'd9;
    #1;
    checks++;
    if (m_in_ready !== 1'b0) $display("FAIL flush_ready: got %0b want 0", m_in_ready);
    else passes++;
    step(1);
    m_flush = 1'b0; m_in_valid = 1'b0;
    checks++;
    if ({m_list_cnt, m_out_valid} !== {5'd0, 1'b0}) $display("FAIL flush_clear: cnt=%0d vld=%0b want 0/0", m_list_cnt, m_out_valid);
    else passes++;
    step(8);
    checks++;
    if ({m_list_cnt, m_in_ready} !== {5'd0, 1'b1} || m_drop_count !== drops0)
      $display("FAIL flush_quiet: cnt=%0d rdy=%0b drops=%0d want 0/1/%0d", m_list_cnt, m_in_ready, m_drop_count, drops0);
    else passes++;
  endtask

  task automatic test_carry();
    logic v;
    logic [72:0] rec;
    logic [72:0] exp_rec [3] = '{{8'd2, 64'h0001, 1'b0}, {8'd4, 64'h0010_0093, 1'b0}, {8'd2, 64'h0001, 1'b0}};
    int drops0;
    drops0 = a_drop_count;
    send_a(DW'(40'h10_0093_0001), 6'd5, 1'b1);
    step(3);
    checks++;
    if ({a_list_cnt, a_in_ready} !== {5'd1, 1'b1}) $display("FAIL carry_retain: cnt=%0d rdy=%0b want 1/1", a_list_cnt, a_in_ready);
    else passes++;
    send_a(DW'(24'h00_0100), 6'd3, 1'b0);
    for (int r = 0; r < 3; r++) begin
      pop_a(v, rec);
      checks++;
      if (!v || rec !== exp_rec[r]) $display("FAIL carry_rec%0d: valid=%0b got %h want %h", r, v, rec, exp_rec[r]);
      else passes++;
    end
    step(3);
    checks++;
    if (a_drop_count !== drops0 || a_list_cnt !== 5'd0) $display("FAIL carry_nodrop: drops=%0d cnt=%0d want %0d/0", a_drop_count, a_list_cnt, drops0);
    else passes++;
  endtask

  task automatic test_width();
    logic v;
    logic [72:0] rec;
    send_a(DW'(48'h0010_0093_003F), 6'd6, 1'b0);
    pop_a(v, rec);
    checks++;
    if (!v || rec !== {8'd2, 64'h003F, 1'b1}) $display("FAIL width_ill: valid=%0b got %h want 2/003f/1", v, rec);
    else passes++;
    pop_a(v, rec);
    checks++;
    if (!v || rec !== {8'd4, 64'h0010_0093, 1'b0}) $display("FAIL width_resume: valid=%0b got %h want 4/00100093/0", v, rec);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_illegal();
    test_discard();
    test_back_to_back();
    test_flush();
    test_carry();
    test_width();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
